vm1_timer_responder: RTL
========================

Name: vm1_timer_responder

Overview:
- Bus responder for the on-chip 1801VM1 programmable timer, sitting on the CPU data bus opposite the datapath's bus initiator.
- Decodes word addresses BASE+06 (reload), BASE+10 (counter) and BASE+12 (control), octal.
- Completes din/dout cycles with a rply handshake.
- Runs a prescaled down-counter with one-shot, wraparound and expiry-flag modes.

Parameters:
- BASE, 16'o177700, decode base; bits [15:4] must match dba[15:4].
- PRESCALE, 128, ce ticks per undivided timer tick; must be at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; all state advances only on clk edges with ce=1.
- dba  in  16  bus address; stable while din or dout is asserted.
- dbo  in  16  write data from the initiator.
- din  in  1  read strobe, level.
- dout  in  1  write strobe, level.
- wtbt  in  1  byte write; lane is selected by dba[0] (0 = low byte, 1 = high byte).
- dbi  out  16  read data; 0 when not replying to a read.
- rply  out  1  reply handshake.
- expired  out  1  mirror of control bit 7.

Behaviour:
- Reset (asynchronous, immediate):
  - rply=0, dbi=0, state=IDLE.
  - reload=0, counter=16'o177777, control=0, prescaler=0, expired=0.
- Address hit: dba[15:4]==BASE[15:4] and dba[3:1] is 3 (reload), 4 (counter) or 5 (control). Any other address: no response, ever.
- Handshake FSM (evaluated on ce only):
  - IDLE -> REPLY when exactly one of din/dout is asserted and the address hits. On that same edge rply<=1; for a read, dbi<=selected register.
  - din and dout asserted together: no reply; stay in IDLE.
  - REPLY: rply and dbi stay stable. When din=0 and dout=0, go to IDLE with rply<=0 and dbi<=0 on the next ce.
  - Latency: rply rises 1 ce edge after the strobe is sampled.
  - A write takes effect exactly once, on the IDLE->REPLY edge.
- Read data:
  - reload: value as stored.
  - counter: live value, sampled on the reply edge.
  - control: {8'hFF, control[7:0]}.
- Writes:
  - Word writes replace the register. Byte writes (wtbt=1) replace only the selected lane.
  - Writes to counter are ignored, but still replied.
  - Control bits 6:0 take the written value.
  - Bit 7 (EXPIRED) clears only when 0 is written to it; writing 1 leaves it unchanged.
  - Any control write clears the prescaler.
- Control bits:
  - 0 STOP: freezes counting when set.
  - 1 WRAP: at zero, wrap to 16'o177777 instead of reloading.
  - 2 EXPEN: enables setting EXPIRED.
  - 3 ONESHOT: clears RUN when zero is reached.
  - 4 RUN: enables the timer.
  - 5 DIV16 and 6 DIV4: extra division of the tick.
  - 7 EXPIRED.
- Start: a control write that changes RUN from 0 to 1 loads counter<=reload on that same edge.
- Prescaler:
  - Counts ce edges while RUN=1 and STOP=0; holds otherwise.
  - Divide limit L = PRESCALE × (DIV4 ? 4 : 1) × (DIV16 ? 16 : 1).
  - When prescaler reaches L-1, it wraps to 0 and emits one tick.
- Tick behaviour:
  - counter != 0: counter <= counter-1.
  - counter == 0: counter <= WRAP ? 16'o177777 : reload; EXPIRED<=1 if EXPEN; RUN<=0 if ONESHOT.
- Simultaneous events:
  - A reload write on the same edge as a zero tick: the reload uses the pre-write reload value.
  - A control write on a tick edge: the write wins for bits 6:0; the tick's counter update is discarded.
  - A tick setting EXPIRED on the same edge as a write clearing it: EXPIRED ends at 1 (set wins).
- Reset mid-cycle: rply drops immediately. The initiator sees no reply and handles it as a bus timeout; this block takes no action.

Test Plan:
- Reset (PRESCALE=4): assert reset_n=0 mid-REPLY -> rply=0, dbi=0 at once; read BASE+12 -> 16'o177400; read BASE+10 -> 16'o177777.
- Handshake: din with dba=16'o177706 after reload was written 16'o000123 -> rply rises 1 ce later with dbi=16'o000123; drop din -> rply=0, dbi=0 next ce. Address 16'o177714 -> rply never rises.
- Byte write: reload=16'h1234, dout+wtbt at 16'o177707 with dbo=16'hAB00 -> reload=16'hAB34.
- Periodic: reload=3, control=16'o000024 (RUN+EXPEN) -> counter 3,2,1,0,3 with one step every 4 ce; EXPIRED and expired set on the 0->reload tick. Writing control 16'o000024 clears EXPIRED.
- One-shot/wrap: control=16'o000032 (RUN+ONESHOT+WRAP), reload=1 -> counter 1,0,177777 then holds; RUN reads back 0.
- Collisions: reload write on the zero-tick edge -> counter gets the old reload. din+dout together -> no rply. DIV4 with PRESCALE=4 -> one tick per 16 ce.

Source files
------------

// File: rtl/vm1_timer_responder.sv
// vm1_timer_responder: bus responder and prescaled down-counter for the
// 1801VM1 on-chip timer. Three word registers sit at BASE+06 (reload),
// BASE+10 (counter) and BASE+12 (control). Every din/dout cycle gets a
// registered rply handshake. All state advances only on clk edges with ce=1.
module vm1_timer_responder #(
  parameter logic [15:0] BASE     = 16'o177700,
  parameter int          PRESCALE = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] dba,
  input  logic [15:0] dbo,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  output logic [15:0] dbi,
  output logic        rply,
  output logic        expired
);

  // The largest divide limit is PRESCALE*4*16. The prescaler only has to hold L-1.
  localparam int PW = $clog2(PRESCALE * 64);

  // Word offsets (dba[3:1]) of the three registers.
  localparam logic [2:0] REG_RELOAD  = 3'd3;
  localparam logic [2:0] REG_COUNTER = 3'd4;
  localparam logic [2:0] REG_CONTROL = 3'd5;

  // Control register bit positions.
  localparam int CTL_STOP    = 0;
  localparam int CTL_WRAP    = 1;
  localparam int CTL_EXPEN   = 2;
  localparam int CTL_ONESHOT = 3;
  localparam int CTL_RUN     = 4;
  localparam int CTL_DIV16   = 5;
  localparam int CTL_DIV4    = 6;
  localparam int CTL_EXPIRED = 7;

  typedef enum logic {
    IDLE,
    REPLY
  } state_t;

  state_t          state;
  logic [15:0]     reload;
  logic [15:0]     counter;
  logic [7:0]      control;
  logic [PW-1:0]   prescaler;
  logic [PW-1:0]   limit_m1;

  logic            hit;
  logic            accept;
  logic            wr_reload;
  logic            wr_control;
  logic            start;
  logic            counting;
  logic            tick;
  logic            at_zero;
  logic            exp_set;
  logic [15:0]     rdata;
  logic [15:0]     reload_wdata;
  logic [15:0]     control_wdata;

  // A word write replaces the whole value. A byte write replaces only the lane picked by dba[0].
  function automatic logic [15:0] merge_lanes(input logic [15:0] cur,
                                              input logic [15:0] wr,
                                              input logic        byte_wr,
                                              input logic        high);
    if (!byte_wr) return wr;
    else if (high) return {wr[15:8], cur[7:0]};
    else return {cur[15:8], wr[7:0]};
  endfunction

  assign hit = (dba[15:4] == BASE[15:4]) &&
               ((dba[3:1] == REG_RELOAD) || (dba[3:1] == REG_COUNTER) ||
                (dba[3:1] == REG_CONTROL));

  // A cycle is taken only with exactly one strobe asserted. This is the single
  // edge on which a write lands.
  assign accept     = ce && (state == IDLE) && (din != dout) && hit;
  assign wr_reload  = accept && dout && (dba[3:1] == REG_RELOAD);
  assign wr_control = accept && dout && (dba[3:1] == REG_CONTROL);

  assign reload_wdata  = merge_lanes(reload, dbo, wtbt, dba[0]);
  assign control_wdata = merge_lanes({8'hFF, control}, dbo, wtbt, dba[0]);
  assign start         = wr_control && !control[CTL_RUN] && control_wdata[CTL_RUN];

  assign counting = control[CTL_RUN] && !control[CTL_STOP];
  assign tick     = ce && counting && (prescaler == limit_m1);
  assign at_zero  = (counter == 16'd0);
  assign exp_set  = tick && at_zero && control[CTL_EXPIRED - 5];

  assign expired = control[CTL_EXPIRED];

  // Divide limit minus one, selected by the DIV4/DIV16 bits.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    limit_m1 = PW'(PRESCALE - 1);
    case ({control[CTL_DIV4], control[CTL_DIV16]})
      2'b01:   limit_m1 = PW'(PRESCALE * 16 - 1);
      2'b10:   limit_m1 = PW'(PRESCALE * 4 - 1);
      2'b11:   limit_m1 = PW'(PRESCALE * 64 - 1);
      default: limit_m1 = PW'(PRESCALE - 1);
    endcase
  end

  // Read mux. The upper control byte always reads as ones.
  always_comb begin
    rdata = 16'd0;
    case (dba[3:1])
      REG_RELOAD:  rdata = reload;
      REG_COUNTER: rdata = counter;
      REG_CONTROL: rdata = {8'hFF, control};
      default:     rdata = 16'd0;
    endcase
  end

  // Handshake FSM with registered rply and dbi.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
    if (!reset_n) begin
      state <= IDLE;
      rply  <= 1'b0;
      dbi   <= 16'd0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= REPLY;
            rply  <= 1'b1;
            dbi   <= din ? rdata : 16'd0;
          end
        end
        REPLY: begin
          if (!din && !dout) begin
            state <= IDLE;
            rply  <= 1'b0;
            dbi   <= 16'd0;
          end
        end
        default: begin
          state <= IDLE;
          rply  <= 1'b0;
          dbi   <= 16'd0;
        end
      endcase
    end
  end

  // Timer registers: bus writes, prescaler, counter ticks and their collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload    <= 16'd0;
      counter   <= 16'o177777;
      control   <= 8'd0;
      prescaler <= '0;
    end else if (ce) begin
      // A control write restarts the division phase. Otherwise count while running.
      if (wr_control)    prescaler <= '0;
      else if (tick)     prescaler <= '0;
      else if (counting) prescaler <= prescaler + PW'(1);

      if (wr_reload) reload <= reload_wdata;

      // A control write overrides a coinciding tick. A zero tick reloads from the pre-write reload.
      if (wr_control) begin
        if (start) counter <= reload;
      end else if (tick) begin
        if (at_zero) counter <= control[CTL_WRAP] ? 16'o177777 : reload;
        else         counter <= counter - 16'd1;
      end

      // EXPIRED clears only on a written 0, and a coinciding set takes priority.
      if (wr_control) begin
        control[6:0]         <= control_wdata[6:0];
        control[CTL_EXPIRED] <= exp_set | (control[CTL_EXPIRED] & control_wdata[CTL_EXPIRED]);
      end else if (tick && at_zero) begin
        if (control[CTL_EXPEN])   control[CTL_EXPIRED] <= 1'b1;
        if (control[CTL_ONESHOT]) control[CTL_RUN]     <= 1'b0;
      end
    end
  end

endmodule
